mlp_feature_framer: RTL

- Upstream front end for the olfactory MLP inference core.
- Takes a serial stream of per-channel sensor samples (one channel per beat) and assembles them into frames of NChan values.
- Averages 2^Log2Avg consecutive frames per channel and presents the averaged NChan-vector with a valid/ready handshake.
- The output vector drives the MLP's 6-entry input array directly.

---
 rtl/mlp_feature_framer.sv | 115 +++++++++++
 1 files changed

// File: rtl/mlp_feature_framer.sv
// Frames a serial per-channel sample stream into NChan-wide vectors and averages
// 2^Log2Avg consecutive frames before handing the vector to the MLP core.
//
// state   | meaning
// COLLECT | accepting samples, accumulating per-channel frame sums
// OUTPUT  | averaged vector held on m_data_o until the consumer takes it
module mlp_feature_framer #(
    parameter int NBits   = 16,
    parameter int NChan   = 6,
    parameter int Log2Avg = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [2:0]               s_chan_i,
    input  logic signed [NBits-1:0]  s_data_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [NChan*NBits-1:0]   m_data_o,
    output logic                     err_o
);

    localparam int AccW = NBits + Log2Avg;
    localparam int FcW  = (Log2Avg > 0) ? Log2Avg : 1;
    localparam logic [FcW-1:0] FcLast   = FcW'((1 << Log2Avg) - 1);
    localparam logic [2:0]     LastChan = 3'(NChan - 1);

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_OUTPUT  = 1'b1
    } state_t;

    state_t                  state;
    logic [2:0]              exp_chan;
    logic [FcW-1:0]          frame_cnt;
    logic signed [AccW-1:0]  acc [NChan];
    logic signed [AccW-1:0]  samp_ext;
    logic signed [AccW-1:0]  frame_sum [NChan];
    logic signed [AccW-1:0]  avg_full [NChan];
    logic [NChan*NBits-1:0]  avg_vec;

    assign samp_ext  = AccW'(s_data_i);
    assign s_ready_o = (state == ST_COLLECT);

    // Averages include the completing sample, which lands on the last channel.
    always_comb begin
        avg_vec = '0;
        for (int k = 0; k < NChan; k++) begin
            frame_sum[k] = acc[k];
            if (k == NChan - 1) frame_sum[k] = acc[k] + samp_ext;
            avg_full[k] = frame_sum[k] >>> Log2Avg;
            avg_vec[k*NBits +: NBits] = avg_full[k][NBits-1:0];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_COLLECT;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            err_o     <= 1'b0;
            exp_chan  <= '0;
            frame_cnt <= '0;
            for (int k = 0; k < NChan; k++) acc[k] <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                ST_COLLECT: begin
                    if (s_valid_i) begin
                        if (s_chan_i == exp_chan) begin
                            if (exp_chan == LastChan) begin
                                exp_chan <= '0;
                                if (frame_cnt == FcLast) begin
                                    m_data_o  <= avg_vec;
                                    m_valid_o <= 1'b1;
                                    frame_cnt <= '0;
                                    state     <= ST_OUTPUT;
                                    for (int k = 0; k < NChan; k++) acc[k] <= '0;
                                end else begin
                                    frame_cnt         <= frame_cnt + FcW'(1);
                                    acc[NChan-1]      <= acc[NChan-1] + samp_ext;
                                end
                            end else begin
                                exp_chan <= exp_chan + 3'd1;
                                for (int k = 0; k < NChan; k++)
                                    if (exp_chan == 3'(k)) acc[k] <= acc[k] + samp_ext;
                            end
                        end else begin
                            // Out-of-order sample: drop everything gathered so far;
                            // a channel-0 sample is kept as the start of a new frame.
                            err_o     <= 1'b1;
                            frame_cnt <= '0;
                            for (int k = 0; k < NChan; k++) acc[k] <= '0;
                            if (s_chan_i == 3'd0) begin
                                acc[0]   <= samp_ext;
                                exp_chan <= 3'd1;
                            end else begin
                                exp_chan <= 3'd0;
                            end
                        end
                    end
                end
                ST_OUTPUT: begin
                    if (m_ready_i) begin
                        m_valid_o <= 1'b0;
                        state     <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule
